game_mode_controller: RTL and testbench

//   Top-level screen sequencer for the Pong design. Decodes the rotary encoder and push button,

---
 rtl/pong_defs.sv | 12 +
 rtl/button_debouncer.sv | 38 +++
 rtl/game_mode_controller.sv | 106 ++++++++++
 tb/tb_game_mode_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pong_defs.sv
// pong_defs: shared screen-mode encoding, pixel width and menu item indices for the Pong design
package pong_defs;
    localparam int RGB_W        = 8;
    localparam int ITEM_PONG    = 0;
    localparam int ITEM_CREDITS = 1;
    typedef enum logic [1:0] {
        MODE_MENU    = 2'd0,
        MODE_GAME    = 2'd1,
        MODE_CREDITS = 2'd2,
        MODE_BAD     = 2'd3
    } mode_e;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a bouncy button, debounces it and emits a 1-cycle press pulse
//   clock, reset (async active-low), btn (async raw button) -> press (pulse on debounced 0->1)
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, level_dly_q;
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == LAST) level_d = ~level_q;
            else cnt_d = cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn};
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end
    assign press = level_q & ~level_dly_q;
endmodule

// File: rtl/game_mode_controller.sv
// game_mode_controller: Pong screen sequencer (encoder cursor, button, MENU/GAME/CREDITS, RGB mux)
//   in : clock, reset (async active-low), rota/rotb (encoder), btn, frame_start, game_over,
//        menu_rgb/game_rgb/credits_rgb (8-bit pixels)
//   out: menu_select (cursor), mode (committed screen), show_credits, game_enable,
//        game_start (pulse on entering GAME), rgb_out (registered pixel of the active screen)
module game_mode_controller
    import pong_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_ITEMS       = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rota,
    input  logic             rotb,
    input  logic             btn,
    input  logic             frame_start,
    input  logic             game_over,
    input  logic [RGB_W-1:0] menu_rgb,
    input  logic [RGB_W-1:0] game_rgb,
    input  logic [RGB_W-1:0] credits_rgb,
    output logic [2:0]       menu_select,
    output logic [1:0]       mode,
    output logic             show_credits,
    output logic             game_enable,
    output logic             game_start,
    output logic [RGB_W-1:0] rgb_out
);
    localparam logic [2:0] SEL_LAST = 3'(NUM_ITEMS - 1);
    logic [2:0]       qa_q, qb_q;
    logic [2:0]       sel_q, sel_d;
    mode_e            mode_q, mode_d, pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             show_credits_q, game_enable_q, game_start_q;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             press, step, up;
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clock (clock),
        .reset (reset),
        .btn   (btn),
        .press (press)
    );
    // qa/qb[1:0] act as the synchronizer; a step is a change between bits 1 and 2 of either phase
    assign step = qa_q[2] ^ qa_q[1] ^ qb_q[2] ^ qb_q[1];
    assign up   = qa_q[2] ^ qb_q[1];
    always_comb begin
        mode_d   = mode_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        sel_d    = sel_q;
        if (mode_q == MODE_BAD) begin
            mode_d   = MODE_MENU;
            pend_v_d = 1'b0;
        end else if (pend_v_q) begin
            // requests while a target is pending are dropped: first request wins
            if (frame_start) begin
                mode_d   = pend_q;
                pend_v_d = 1'b0;
            end
        end else if (mode_q == MODE_MENU && press) begin
            pend_v_d = 1'b1;
            pend_d   = (sel_q == 3'(ITEM_PONG)) ? MODE_GAME : MODE_CREDITS;
        end else if ((mode_q == MODE_CREDITS && press) || (mode_q == MODE_GAME && game_over)) begin
            pend_v_d = 1'b1;
            pend_d   = MODE_MENU;
        end
        if (step && mode_q == MODE_MENU && !pend_v_q)
            sel_d = up ? ((sel_q == SEL_LAST) ? sel_q : sel_q + 3'd1)
                       : ((sel_q == 3'd0) ? sel_q : sel_q - 3'd1);
        rgb_d = (mode_q == MODE_MENU)    ? menu_rgb :
                (mode_q == MODE_GAME)    ? game_rgb :
                (mode_q == MODE_CREDITS) ? credits_rgb : '0;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            qa_q           <= '0;
            qb_q           <= '0;
            sel_q          <= '0;
            mode_q         <= MODE_MENU;
            pend_q         <= MODE_MENU;
            pend_v_q       <= 1'b0;
            show_credits_q <= 1'b0;
            game_enable_q  <= 1'b0;
            game_start_q   <= 1'b0;
            rgb_q          <= '0;
        end else begin
            qa_q           <= {qa_q[1:0], rota};
            qb_q           <= {qb_q[1:0], rotb};
            sel_q          <= sel_d;
            mode_q         <= mode_d;
            pend_q         <= pend_d;
            pend_v_q       <= pend_v_d;
            // flags are derived from mode_d so they move in the same cycle as mode
            show_credits_q <= (mode_d == MODE_CREDITS);
            game_enable_q  <= (mode_d == MODE_GAME);
            game_start_q   <= (mode_d == MODE_GAME) && (mode_q != MODE_GAME);
            rgb_q          <= rgb_d;
        end
    end
    assign menu_select  = sel_q;
    assign mode         = mode_q;
    assign show_credits = show_credits_q;
    assign game_enable  = game_enable_q;
    assign game_start   = game_start_q;
    assign rgb_out      = rgb_q;
endmodule

// File: tb/tb_game_mode_controller.sv
// tb_game_mode_controller: directed scoreboard bench for game_mode_controller
module tb_game_mode_controller;
  localparam int K_MODE = 0, K_SEL = 1, K_RGB = 2, K_GS = 3, K_GE = 4, K_SC = 5, K_GSCNT = 6;
  logic       clock = 1'b0, reset = 1'b0, rota = 1'b0, rotb = 1'b0, btn = 1'b0;
  logic       frame_start = 1'b0, game_over = 1'b0;
  logic [7:0] menu_rgb = 8'hE0, game_rgb = 8'h1C, credits_rgb = 8'h03;
  logic [2:0] menu_select;
  logic [1:0] mode;
  logic       show_credits, game_enable, game_start;
  logic [7:0] rgb_out;
  logic       done = 1'b0;
  int         checks = 0, failures = 0, gs_cnt = 0, sel_m = 0;
  typedef struct {
    string name;
    int    kind;
    int    exp;
  } chk_t;
  chk_t sb[$];
  always #5 clock = ~clock;
  game_mode_controller #(.DEBOUNCE_CYCLES(4), .NUM_ITEMS(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .rota         (rota),
    .rotb         (rotb),
    .btn          (btn),
    .frame_start  (frame_start),
    .game_over    (game_over),
    .menu_rgb     (menu_rgb),
    .game_rgb     (game_rgb),
    .credits_rgb  (credits_rgb),
    .menu_select  (menu_select),
    .mode         (mode),
    .show_credits (show_credits),
    .game_enable  (game_enable),
    .game_start   (game_start),
    .rgb_out      (rgb_out)
  );
  always @(posedge clock) if (game_start === 1'b1) gs_cnt++;
  function automatic int actual(input int kind);
    case (kind)
      K_MODE:  return int'(mode);
      K_SEL:   return int'(menu_select);
      K_RGB:   return int'(rgb_out);
      K_GS:    return int'(game_start);
      K_GE:    return int'(game_enable);
      K_SC:    return int'(show_credits);
      default: return gs_cnt;
    endcase
  endfunction
  always @(negedge clock) begin
    chk_t c;
    int   a;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      a = actual(c.kind);
      checks++;
      if (a != c.exp) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", c.name, a, c.exp, $time);
      end
    end
  end
  initial begin
    #200000;
    if (!done) begin
      failures++;
      $display("FAIL timeout: sequence did not finish at %0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end
  task automatic expect_v(input string n, input int k, input int v);
    sb.push_back('{n, k, v});
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask
  task automatic press_btn();
    btn = 1'b1;
    repeat (6) tick();
    btn = 1'b0;
    repeat (12) tick();
  endtask
  task automatic enc_detent(input bit dir_up, input bit live);
    for (int i = 0; i < 4; i++) begin
      if (dir_up == (i % 2 == 0)) rotb = ~rotb;
      else rota = ~rota;
      repeat (4) tick();
      if (live) sel_m = dir_up ? ((sel_m < 1) ? sel_m + 1 : 1) : ((sel_m > 0) ? sel_m - 1 : 0);
    end
    expect_v(dir_up ? "sel_after_up" : "sel_after_down", K_SEL, sel_m);
  endtask
  initial begin
    repeat (3) tick();
    checks++;
    if (mode !== 2'd0 || menu_select !== 3'd0 || rgb_out !== 8'd0 ||
        game_start !== 1'b0 || game_enable !== 1'b0 || show_credits !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: mode=%0h sel=%0h rgb=%0h gs=%0b ge=%0b sc=%0b at %0t",
               mode, menu_select, rgb_out, game_start, game_enable, show_credits, $time);
    end
    expect_v("rst_mode", K_MODE, 0);
    expect_v("rst_sel", K_SEL, 0);
    expect_v("rst_rgb", K_RGB, 0);
    expect_v("rst_game_start", K_GS, 0);
    expect_v("rst_game_enable", K_GE, 0);
    expect_v("rst_show_credits", K_SC, 0);
    reset = 1'b1;
    expect_v("rgb_at_release", K_RGB, 0);
    tick();
    expect_v("rgb_menu", K_RGB, 8'hE0);
    expect_v("mode_menu", K_MODE, 0);
    repeat (3) enc_detent(1'b1, 1'b1);
    repeat (5) enc_detent(1'b0, 1'b1);
    btn = 1'b1;
    repeat (2) tick();
    btn = 1'b0;
    repeat (2) tick();
    btn = 1'b1;
    repeat (6) tick();
    btn = 1'b0;
    repeat (10) tick();
    expect_v("mode_before_frame", K_MODE, 0);
    expect_v("ge_before_frame", K_GE, 0);
    frame();
    expect_v("mode_game", K_MODE, 1);
    expect_v("game_start_pulse", K_GS, 1);
    expect_v("game_enable_on", K_GE, 1);
    expect_v("sc_in_game", K_SC, 0);
    tick();
    expect_v("game_start_drop", K_GS, 0);
    expect_v("rgb_game", K_RGB, 8'h1C);
    expect_v("game_start_count", K_GSCNT, 1);
    press_btn();
    frame();
    expect_v("press_ignored_in_game", K_MODE, 1);
    game_over   = 1'b1;
    frame_start = 1'b1;
    tick();
    game_over   = 1'b0;
    frame_start = 1'b0;
    expect_v("over_with_frame_stays", K_MODE, 1);
    repeat (3) tick();
    frame();
    expect_v("over_commit_menu", K_MODE, 0);
    expect_v("ge_off", K_GE, 0);
    tick();
    expect_v("rgb_menu_again", K_RGB, 8'hE0);
    enc_detent(1'b1, 1'b1);
    press_btn();
    expect_v("mode_before_credits", K_MODE, 0);
    frame();
    expect_v("mode_credits", K_MODE, 2);
    expect_v("sc_on", K_SC, 1);
    expect_v("no_game_start_credits", K_GS, 0);
    tick();
    expect_v("rgb_credits", K_RGB, 8'h03);
    enc_detent(1'b0, 1'b0);
    press_btn();
    frame();
    expect_v("credits_to_menu", K_MODE, 0);
    expect_v("sc_off", K_SC, 0);
    expect_v("sel_kept", K_SEL, 1);
    enc_detent(1'b0, 1'b1);
    press_btn();
    enc_detent(1'b1, 1'b0);
    reset = 1'b0;
    tick();
    expect_v("mid_reset_mode", K_MODE, 0);
    expect_v("mid_reset_rgb", K_RGB, 0);
    reset = 1'b1;
    tick();
    frame();
    expect_v("pending_lost", K_MODE, 0);
    expect_v("no_game_enable", K_GE, 0);
    tick();
    expect_v("no_game_start_after_reset", K_GS, 0);
    expect_v("game_start_count_final", K_GSCNT, 1);
    repeat (3) tick();
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
